chacha_keystream_engine: RTL and testbench

- Parametrised ChaCha block-function engine, Avalon-MM configured, 512-bit Avalon-ST keystream/ciphertext source.
- Generalises the single-variant core in four ways:
  - configurable round count (ChaCha8/12/20);
  - 1 or 2 rounds per cycle;
  - RFC 8439 feed-forward addition;
  - optional 64-bit block counter.
- Adds an in-line XOR mode: a 512-bit plaintext sink is combined with the keystream, so software gets ciphertext directly.

---
 rtl/chacha_keystream_engine.sv | 115 +++++++++++
 tb/tb_chacha_keystream_engine.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/chacha_keystream_engine.sv
// chacha_keystream_engine: ChaCha block engine with CSR config and 512-bit keystream/ciphertext stream
module chacha_keystream_engine #(
  parameter int DOUBLE_ROUNDS = 10,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int COUNTER_64 = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         csr_write,
  input  logic         csr_read,
  input  logic [4:0]   csr_address,
  input  logic [31:0]  csr_writedata,
  output logic [31:0]  csr_readdata,
  input  logic [511:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [511:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam logic [1:0] IDLE = 2'd0, ROUND = 2'd1, COMBINE = 2'd2, OUTPUT = 2'd3;
  localparam logic [4:0] LAST = 5'(2 * DOUBLE_ROUNDS);
  localparam logic [4:0] STEP = 5'(ROUNDS_PER_CYCLE);
  logic [1:0]   state;
  logic [4:0]   round_idx;
  logic [511:0] init_state, work, ks, rnd1, rnd2, init_next;
  logic [31:0]  blocks_remaining, status, rd_mux;
  logic         xor_en;
  function automatic logic [511:0] qr(input logic [511:0] s, input int a, input int b, input int c, input int d);
    logic [31:0] x, y, z, w;
    x = s[32*a+:32];
    y = s[32*b+:32];
    z = s[32*c+:32];
    w = s[32*d+:32];
    x = x + y; w = w ^ x; w = {w[15:0], w[31:16]};
    z = z + w; y = y ^ z; y = {y[19:0], y[31:20]};
    x = x + y; w = w ^ x; w = {w[23:0], w[31:24]};
    z = z + w; y = y ^ z; y = {y[24:0], y[31:25]};
    s[32*a+:32] = x;
    s[32*b+:32] = y;
    s[32*c+:32] = z;
    s[32*d+:32] = w;
    return s;
  endfunction
  function automatic logic [511:0] chacha_round(input logic [511:0] s, input logic diag);
    return diag ? qr(qr(qr(qr(s, 0, 5, 10, 15), 1, 6, 11, 12), 2, 7, 8, 13), 3, 4, 9, 14)
                : qr(qr(qr(qr(s, 0, 4, 8, 12), 1, 5, 9, 13), 2, 6, 10, 14), 3, 7, 11, 15);
  endfunction
  assign in_ready = state == COMBINE && xor_en;
  assign status = {19'd0, round_idx, 6'd0, out_valid, state != IDLE};
  always_comb begin
    rnd1 = chacha_round(work, round_idx[0]);
    rnd2 = ROUNDS_PER_CYCLE == 2 ? chacha_round(rnd1, ~round_idx[0]) : rnd1;
    for (int i = 0; i < 16; i++) ks[32*i+:32] = work[32*i+:32] + init_state[32*i+:32];
    init_next = init_state;
    init_next[384+:32] = init_state[384+:32] + 32'd1;
    init_next[416+:32] = (COUNTER_64 != 0 && &init_state[384+:32]) ? init_state[416+:32] + 32'd1 : init_state[416+:32];
    rd_mux = csr_address < 5'd16 ? init_state[32*csr_address[3:0]+:32] :
             csr_address == 5'd16 ? blocks_remaining :
             csr_address == 5'd17 ? status :
             csr_address == 5'd18 ? {31'd0, xor_en} : 32'hC4AC_0002;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      round_idx <= '0;
      out_valid <= 1'b0;
      blocks_remaining <= '0;
      xor_en <= 1'b0;
      csr_readdata <= '0;
    end else begin
      if (csr_read) csr_readdata <= rd_mux;
      if (csr_write && (csr_address < 5'd16 || csr_address == 5'd18)) begin
        state <= IDLE;
        out_valid <= 1'b0;
        if (csr_address[4]) xor_en <= csr_writedata[0];
        else init_state[32*csr_address[3:0]+:32] <= csr_writedata;
      end else if (csr_write && csr_address == 5'd16) begin
        blocks_remaining <= csr_writedata;
        out_valid <= 1'b0;
        work <= init_state;
        round_idx <= '0;
        state <= csr_writedata != 0 ? ROUND : IDLE;
      end else begin
        case (state)
          ROUND: begin
            if (round_idx == LAST) state <= COMBINE;
            else begin
              work <= rnd2;
              round_idx <= round_idx + STEP;
            end
          end
          COMBINE: begin
            if (!xor_en || in_valid) begin
              out_data <= xor_en ? ks ^ in_data : ks;
              out_valid <= 1'b1;
              state <= OUTPUT;
            end
          end
          OUTPUT: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              init_state <= init_next;
              work <= init_next;
              round_idx <= '0;
              blocks_remaining <= blocks_remaining - 32'd1;
              state <= blocks_remaining == 32'd1 ? IDLE : ROUND;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_chacha_keystream_engine.sv
// tb_chacha_keystream_engine: vector table plus randomized blocks against a software ChaCha model
module tb_chacha_keystream_engine;
  typedef struct {
    int k;
    int n;
    logic [31:0] w12;
    logic [31:0] w13;
    int stall;
    int lat;
    logic [31:0] f12;
    logic [31:0] f13;
  } vec_t;
  logic clock = 0, reset = 1, csr_read = 0, csr_write = 0, in_valid = 0, out_ready = 0;
  logic [3:0] sel = 0;
  logic [4:0] csr_address = 0;
  logic [31:0] csr_writedata = 0;
  logic [511:0] in_data = 0;
  logic [31:0] rd[4];
  logic [511:0] od[4];
  logic ov[4], ir[4];
  logic [31:0] ms[16];
  logic [511:0] last_od, rfc_ks;
  int checks = 0, fails = 0;
  always #5 clock = ~clock;
  for (genvar g = 0; g < 4; g++) begin : d
    chacha_keystream_engine #(
      .DOUBLE_ROUNDS(g == 2 ? 4 : g == 3 ? 6 : 10),
      .ROUNDS_PER_CYCLE(g == 2 ? 2 : 1),
      .COUNTER_64(g == 1 ? 1 : 0)
    ) u (
      .clock(clock), .reset(reset),
      .csr_write(csr_write & sel[g]), .csr_read(csr_read),
      .csr_address(csr_address), .csr_writedata(csr_writedata), .csr_readdata(rd[g]),
      .in_data(in_data), .in_valid(in_valid & sel[g]), .in_ready(ir[g]),
      .out_data(od[g]), .out_valid(ov[g]), .out_ready(out_ready & sel[g])
    );
  end
  function automatic int dr_of(int k);
    return k == 2 ? 4 : k == 3 ? 6 : 10;
  endfunction
  function automatic int lat_of(int k);
    return 2 * dr_of(k) / (k == 2 ? 2 : 1) + 2;
  endfunction
  function automatic logic [31:0] rotl(logic [31:0] v, int n);
    return (v << n) | (v >> (32 - n));
  endfunction
  // Reference ChaCha block over the current model state ms, with feed-forward
  function automatic logic [511:0] model_block(int dr);
    logic [31:0] x[16];
    int q[8][4] = '{'{0,4,8,12}, '{1,5,9,13}, '{2,6,10,14}, '{3,7,11,15},
                    '{0,5,10,15}, '{1,6,11,12}, '{2,7,8,13}, '{3,4,9,14}};
    int a, b, c, e;
    logic [511:0] r;
    x = ms;
    for (int i = 0; i < dr; i++)
      for (int j = 0; j < 8; j++) begin
        a = q[j][0]; b = q[j][1]; c = q[j][2]; e = q[j][3];
        x[a] = x[a] + x[b]; x[e] = rotl(x[e] ^ x[a], 16);
        x[c] = x[c] + x[e]; x[b] = rotl(x[b] ^ x[c], 12);
        x[a] = x[a] + x[b]; x[e] = rotl(x[e] ^ x[a], 8);
        x[c] = x[c] + x[e]; x[b] = rotl(x[b] ^ x[c], 7);
      end
    for (int i = 0; i < 16; i++) r[32*i+:32] = x[i] + ms[i];
    return r;
  endfunction
  task automatic chk(string nm, logic [511:0] act, logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic wr(int k, int a, logic [31:0] v);
    sel = 4'(1 << k);
    csr_write = 1; csr_address = 5'(a); csr_writedata = v;
    @(posedge clock); #1;
    csr_write = 0;
  endtask
  task automatic rd_reg(int k, int a, output logic [31:0] v);
    csr_read = 1; csr_address = 5'(a);
    @(posedge clock); #1;
    csr_read = 0;
    v = rd[k];
  endtask
  task automatic set_ms(logic [31:0] w12, logic [31:0] w13);
    ms[0] = 32'h61707865; ms[1] = 32'h3320646e; ms[2] = 32'h79622d32; ms[3] = 32'h6b206574;
    for (int i = 4; i < 12; i++) ms[i] = $urandom;
    ms[12] = w12; ms[13] = w13; ms[14] = $urandom; ms[15] = $urandom;
  endtask
  task automatic set_rfc();
    ms[0] = 32'h61707865; ms[1] = 32'h3320646e; ms[2] = 32'h79622d32; ms[3] = 32'h6b206574;
    for (int i = 4; i < 12; i++) ms[i] = {8'(4*i-13), 8'(4*i-14), 8'(4*i-15), 8'(4*i-16)};
    ms[12] = 32'h1; ms[13] = 32'h09000000; ms[14] = 32'h4a000000; ms[15] = 32'h0;
  endtask
  task automatic run(int k, int n, int stall, bit xe, int idly, logic [511:0] din, int lat);
    int t;
    logic [511:0] exp;
    for (int i = 0; i < 16; i++) wr(k, i, ms[i]);
    wr(k, 18, {31'd0, xe});
    wr(k, 16, n);
    for (int b = 0; b < n; b++) begin
      exp = model_block(dr_of(k)) ^ (xe ? din : 512'd0);
      t = 0;
      if (xe) begin
        while (!ir[k] && t < 100) begin @(posedge clock); #1; t++; end
        chk("in_ready_latency", 512'(t), 512'(lat - 1));
        repeat (idly) begin
          @(posedge clock); #1;
          chk("combine_stall", 512'({ir[k], ov[k]}), 512'(2'b10));
        end
        in_data = din; in_valid = 1;
        @(posedge clock); #1;
        in_valid = 0;
        chk("xor_accept", 512'({ir[k], ov[k]}), 512'(2'b01));
      end else begin
        while (!ov[k] && t < 100) begin @(posedge clock); #1; t++; end
        chk("latency", 512'(t), 512'(lat));
      end
      chk("block_data", od[k], exp);
      last_od = od[k];
      repeat (stall) begin
        @(posedge clock); #1;
        chk("backpressure_hold", 512'({ov[k], od[k]}), 512'({1'b1, exp}));
      end
      out_ready = 1;
      @(posedge clock); #1;
      out_ready = 0;
      chk("valid_drop", 512'(ov[k]), 512'(0));
      if (k == 1) {ms[13], ms[12]} = {ms[13], ms[12]} + 64'd1;
      else ms[12] = ms[12] + 32'd1;
    end
  endtask
  initial begin
    vec_t tbl[6];
    logic [31:0] v;
    logic [511:0] din;
    int k, t, seen;
    tbl[0] = '{0, 1, 32'h1, 32'h0, 0, 22, 32'h2, 32'h0};
    tbl[1] = '{0, 3, 32'h1, 32'h0, 5, 22, 32'h4, 32'h0};
    tbl[2] = '{1, 2, 32'hFFFFFFFF, 32'h7, 0, 22, 32'h1, 32'h8};
    tbl[3] = '{0, 2, 32'hFFFFFFFF, 32'h7, 0, 22, 32'h1, 32'h7};
    tbl[4] = '{2, 2, 32'h5, 32'h0, 1, 6, 32'h7, 32'h0};
    tbl[5] = '{3, 2, 32'h9, 32'h0, 2, 14, 32'hB, 32'h0};
    repeat (2) @(posedge clock);
    #1 reset = 0;
    chk("reset_readdata", 512'(rd[0]), 512'(0));
    chk("reset_out_valid", 512'({ov[0], ov[1], ov[2], ov[3]}), 512'(0));
    chk("reset_in_ready", 512'({ir[0], ir[1], ir[2], ir[3]}), 512'(0));
    rd_reg(0, 16, v); chk("reset_blocks", 512'(v), 512'(0));
    rd_reg(0, 17, v); chk("reset_status", 512'(v), 512'(0));
    rd_reg(0, 18, v); chk("reset_ctrl", 512'(v), 512'(0));
    rd_reg(0, 20, v); chk("unmapped_read", 512'(v), 512'(32'hC4AC_0002));
    set_rfc();
    rfc_ks = model_block(10);
    sel = 4'b0001;
    run(0, 1, 0, 0, 0, '0, 22);
    chk("rfc_word0", 512'(last_od[31:0]), 512'(32'he4e7f110));
    chk("rfc_word15", 512'(last_od[511:480]), 512'(32'h4e3c50a2));
    rd_reg(0, 12, v); chk("rfc_word12", 512'(v), 512'(2));
    rd_reg(0, 17, v); chk("rfc_idle", 512'(v[0]), 512'(0));
    set_rfc();
    run(0, 1, 0, 1, 4, '0, 22);
    chk("xor_zero_plain", last_od, rfc_ks);
    set_rfc();
    run(0, 1, 1, 1, 0, rfc_ks, 22);
    chk("xor_self_cancel", last_od, 512'd0);
    for (int i = 0; i < 6; i++) begin
      set_ms(tbl[i].w12, tbl[i].w13);
      sel = 4'(1 << tbl[i].k);
      run(tbl[i].k, tbl[i].n, tbl[i].stall, 0, 0, '0, tbl[i].lat);
      rd_reg(tbl[i].k, 12, v); chk("final_word12", 512'(v), 512'(tbl[i].f12));
      rd_reg(tbl[i].k, 13, v); chk("final_word13", 512'(v), 512'(tbl[i].f13));
      rd_reg(tbl[i].k, 16, v); chk("final_blocks", 512'(v), 512'(0));
    end
    set_ms(32'h10, 32'h0);
    for (int i = 0; i < 16; i++) wr(0, i, ms[i]);
    wr(0, 18, 0);
    wr(0, 16, 1);
    repeat (5) @(posedge clock);
    #1 wr(0, 4, 32'h1234);
    rd_reg(0, 17, v); chk("abort_idle", 512'(v[0]), 512'(0));
    seen = 0;
    repeat (30) begin @(posedge clock); #1; seen += int'(ov[0]); end
    chk("abort_no_output", 512'(seen), 512'(0));
    wr(0, 16, 1);
    t = 0;
    while (!ov[0] && t < 100) begin @(posedge clock); #1; t++; end
    chk("pre_reset_output", 512'(ov[0]), 512'(1));
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    chk("reset_drop_valid", 512'(ov[0]), 512'(0));
    rd_reg(0, 17, v); chk("reset_not_busy", 512'(v[0]), 512'(0));
    seen = 0;
    repeat (30) begin @(posedge clock); #1; seen += int'(ov[0]); end
    chk("reset_no_output", 512'(seen), 512'(0));
    for (int it = 0; it < 10; it++) begin
      k = $urandom_range(0, 3);
      set_ms($urandom, $urandom);
      for (int i = 0; i < 16; i++) din[32*i+:32] = $urandom;
      sel = 4'(1 << k);
      run(k, $urandom_range(1, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3), din, lat_of(k));
      rd_reg(k, 12, v); chk("rand_word12", 512'(v), 512'(ms[12]));
      rd_reg(k, 13, v); chk("rand_word13", 512'(v), 512'(ms[13]));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
